icache_fa_mport: RTL and testbench

//  Parametrised fully-associative, PC-tagged instruction cache with N combinational read ports and 1 write port.

---
 rtl/icache_fa_mport.sv | 165 ++++++++++++++++
 tb/tb_icache_fa_mport.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fa_mport.sv
// icache_fa_mport
//   Fully-associative, PC-tagged instruction cache. It sits between the fetch
//   stage and the instruction-bus refill path. Fetch can look up RD_PORTS PCs
//   per cycle through combinational read ports. Refill writes one line per
//   cycle, and victims are chosen in FIFO order.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   rd_en[RD_PORTS]       per-port read enable
//   rd_pc                 packed lookup PCs, port k = [k*PC_W +: PC_W]
//   rd_hit[RD_PORTS]      per-port hit
//   rd_inst               packed instructions, port k = [k*INST_W +: INST_W]
//   wr_en/wr_pc/wr_inst   refill write (in-place update if the tag is present)
//   inv_en/inv_pc         invalidate the line tagged inv_pc
//   flush                 invalidate every line and restart the victim pointer
//   count, full           number of valid lines; count == ENTRIES
//   hit_cnt, miss_cnt     saturating lookup statistics (only with the macro)
//
// Build option
//   ICACHE_PERF_CNT_EN : adds the hit_cnt/miss_cnt ports and counters.

module icache_fa_mport #(
  parameter int ENTRIES  = 32,
  parameter int RD_PORTS = 2,
  parameter int PC_W     = 32,
  parameter int INST_W   = 32,
  localparam int PTR_W   = $clog2(ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [RD_PORTS-1:0]        rd_en,
  input  logic [RD_PORTS*PC_W-1:0]   rd_pc,
  output logic [RD_PORTS-1:0]        rd_hit,
  output logic [RD_PORTS*INST_W-1:0] rd_inst,
  input  logic                       wr_en,
  input  logic [PC_W-1:0]            wr_pc,
  input  logic [INST_W-1:0]          wr_inst,
  input  logic                       inv_en,
  input  logic [PC_W-1:0]            inv_pc,
  input  logic                       flush,
`ifdef ICACHE_PERF_CNT_EN
  output logic [31:0]                hit_cnt,
  output logic [31:0]                miss_cnt,
`endif
  output logic [PTR_W:0]             count,
  output logic                       full
);

  logic [PC_W-1:0]   tag  [ENTRIES];
  logic [INST_W-1:0] data [ENTRIES];
  logic [ENTRIES-1:0] valid;
  logic [PTR_W-1:0]   wptr;

  logic             wr_hit, inv_hit;
  logic [PTR_W-1:0] wr_idx, inv_idx;
  logic             write_alloc, inv_apply, cnt_inc, cnt_dec;

  // Tag match for the write and invalidate ports. The loop runs downward,
  // so the lowest matching index wins. Only one line can match anyway.
  always_comb begin
    wr_hit  = 1'b0;
    wr_idx  = '0;
    inv_hit = 1'b0;
    inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == wr_pc) begin
        wr_hit = 1'b1;
        wr_idx = PTR_W'(i);
      end
      if (valid[i] && tag[i] == inv_pc) begin
        inv_hit = 1'b1;
        inv_idx = PTR_W'(i);
      end
    end
  end

  // Read ports: independent combinational lookups, lowest match wins.
  always_comb begin
    rd_hit  = '0;
    rd_inst = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (rd_en[k] && valid[i] && tag[i] == rd_pc[k*PC_W +: PC_W]) begin
          rd_hit[k]                  = 1'b1;
          rd_inst[k*INST_W +: INST_W] = data[i];
        end
      end
    end
  end

  // A write to the same PC as an invalidate takes priority. An invalidate
  // of the line that is being reallocated this cycle does not reduce the
  // count, because that line is valid again afterwards.
  always_comb begin
    write_alloc = wr_en & ~wr_hit;
    inv_apply   = inv_en & inv_hit & ~(wr_en && (wr_pc == inv_pc));
    cnt_inc     = write_alloc & ~valid[wptr];
    cnt_dec     = inv_apply & ~(write_alloc && (inv_idx == wptr));
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (inv_apply)
        valid[inv_idx] <= 1'b0;
      if (write_alloc) begin
        valid[wptr] <= 1'b1;
        wptr        <= wptr + PTR_W'(1);
      end
      count <= count + (PTR_W+1)'(cnt_inc) - (PTR_W+1)'(cnt_dec);
    end
  end

  // Tag and data arrays have no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      if (wr_hit) begin
        data[wr_idx] <= wr_inst;
      end else begin
        tag[wptr]  <= wr_pc;
        data[wptr] <= wr_inst;
      end
    end
  end

  assign full = (count == (PTR_W+1)'(ENTRIES));

`ifdef ICACHE_PERF_CNT_EN
  localparam int CW = $clog2(RD_PORTS + 1);

  logic [CW-1:0] nhit, nmiss;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [CW-1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_comb begin
    nhit  = '0;
    nmiss = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      if (rd_en[k]) begin
        if (rd_hit[k]) nhit  = nhit + CW'(1);
        else           nmiss = nmiss + CW'(1);
      end
    end
  end

  // Statistics survive a flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt  <= sat_add(hit_cnt, nhit);
      miss_cnt <= sat_add(miss_cnt, nmiss);
    end
  end
`endif

endmodule

// File: tb/tb_icache_fa_mport.sv
module tb_icache_fa_mport;
  localparam int ENTRIES  = 32;
  localparam int RD_PORTS = 2;
  localparam int PC_W     = 32;
  localparam int INST_W   = 32;
  localparam int PTR_W    = $clog2(ENTRIES);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [RD_PORTS-1:0]        rd_en;
  logic [RD_PORTS*PC_W-1:0]   rd_pc;
  logic [RD_PORTS-1:0]        rd_hit;
  logic [RD_PORTS*INST_W-1:0] rd_inst;
  logic                       wr_en;
  logic [PC_W-1:0]            wr_pc;
  logic [INST_W-1:0]          wr_inst;
  logic                       inv_en;
  logic [PC_W-1:0]            inv_pc;
  logic                       flush;
  logic [PTR_W:0]             count;
  logic                       full;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]                hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  icache_fa_mport #(
    .ENTRIES(ENTRIES), .RD_PORTS(RD_PORTS), .PC_W(PC_W), .INST_W(INST_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_pc(rd_pc), .rd_hit(rd_hit), .rd_inst(rd_inst),
    .wr_en(wr_en), .wr_pc(wr_pc), .wr_inst(wr_inst),
    .inv_en(inv_en), .inv_pc(inv_pc), .flush(flush),
`ifdef ICACHE_PERF_CNT_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .count(count), .full(full)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  hit;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic [31:0] cnt;
    logic        full;
  } exp_t;

  exp_t  sbq[$];
  string nameq[$];

  typedef struct {
    logic [1:0]  en;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic [1:0]  hit;
    logic [31:0] i0;
    logic [31:0] i1;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [31:0] pcof(input int i);
    return 32'h1C00_0000 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] dof(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [1:0] hit, input logic [31:0] i0,
                          input logic [31:0] i1, input int cnt, input logic f);
    exp_t e;
    e.hit = hit; e.inst0 = i0; e.inst1 = i1; e.cnt = 32'(cnt); e.full = f;
    sbq.push_back(e);
    nameq.push_back(name);
  endtask

  task automatic check_out();
    exp_t  e;
    string n;
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = sbq.pop_front();
    n = nameq.pop_front();
    cmp({n, ".hit"},   32'(rd_hit), 32'(e.hit));
    cmp({n, ".inst0"}, rd_inst[31:0], e.inst0);
    cmp({n, ".inst1"}, rd_inst[63:32], e.inst1);
    cmp({n, ".count"}, 32'(count), e.cnt);
    cmp({n, ".full"},  32'(full), 32'(e.full));
  endtask

  task automatic probe(input string name, input logic [1:0] en, input logic [31:0] pc0,
                       input logic [31:0] pc1, input logic [1:0] hit, input logic [31:0] i0,
                       input logic [31:0] i1, input int cnt, input logic f);
    rd_en = en;
    rd_pc = {pc1, pc0};
    push_exp(name, hit, i0, i1, cnt, f);
    check_out();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    inv_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic write(input logic [31:0] pc, input logic [31:0] inst);
    wr_en = 1'b1; wr_pc = pc; wr_inst = inst;
    tick();
  endtask

  task automatic invalidate(input logic [31:0] pc);
    inv_en = 1'b1; inv_pc = pc;
    tick();
  endtask

  task automatic do_reset();
    rd_en = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{en: 2'b11, pc0: 32'h1C00_0100, pc1: 32'h1C00_0100, hit: 2'b11, i0: 32'hBBBB_0000, i1: 32'hBBBB_0000};
    tbl[1] = '{en: 2'b01, pc0: 32'h1C00_0200, pc1: 32'h1C00_0300, hit: 2'b01, i0: 32'h1111_1111, i1: 32'h0};
    tbl[2] = '{en: 2'b10, pc0: 32'h1C00_0200, pc1: 32'h1C00_0300, hit: 2'b10, i0: 32'h0, i1: 32'h2222_2222};
    tbl[3] = '{en: 2'b11, pc0: 32'h1C00_0400, pc1: 32'h1C00_0300, hit: 2'b10, i0: 32'h0, i1: 32'h2222_2222};
    tbl[4] = '{en: 2'b00, pc0: 32'h1C00_0100, pc1: 32'h1C00_0200, hit: 2'b00, i0: 32'h0, i1: 32'h0};

    rd_en = '0; rd_pc = '0; wr_en = 1'b0; wr_pc = '0; wr_inst = '0;
    inv_en = 1'b0; inv_pc = '0; flush = 1'b0; rst_n = 1'b0;

    // Reset state
    do_reset();
    probe("reset", 2'b11, 32'h1C00_0000, 32'h1234_5678, 2'b00, 0, 0, 0, 1'b0);

    // Single refill, read on port1 with a miss on port0
    write(32'h1C00_0000, 32'h0280_0C0C);
    probe("refill", 2'b11, 32'h1C00_0004, 32'h1C00_0000, 2'b10, 0, 32'h0280_0C0C, 1, 1'b0);

    // Duplicate write updates in place
    do_reset();
    write(32'h1C00_0100, 32'hAAAA_0000);
    write(32'h1C00_0100, 32'hBBBB_0000);
    probe("dup", 2'b01, 32'h1C00_0100, 32'h0, 2'b01, 32'hBBBB_0000, 0, 1, 1'b0);
    cmp("dup.wptr", 32'(dut.wptr), 32'd1);

    // Table-driven reads over three lines
    write(32'h1C00_0200, 32'h1111_1111);
    write(32'h1C00_0300, 32'h2222_2222);
    for (int v = 0; v < 5; v++)
      probe($sformatf("tbl%0d", v), tbl[v].en, tbl[v].pc0, tbl[v].pc1,
            tbl[v].hit, tbl[v].i0, tbl[v].i1, 3, 1'b0);

    // Invalidate hit, invalidate miss, refill into the next slot
    invalidate(32'h1C00_0200);
    probe("inv", 2'b11, 32'h1C00_0200, 32'h1C00_0300, 2'b10, 0, 32'h2222_2222, 2, 1'b0);
    invalidate(32'h1C00_0900);
    probe("inv_miss", 2'b01, 32'h1C00_0100, 32'h0, 2'b01, 32'hBBBB_0000, 0, 2, 1'b0);
    write(32'h1C00_0500, 32'h5555_5555);
    probe("post_inv_wr", 2'b11, 32'h1C00_0500, 32'h1C00_0300, 2'b11,
          32'h5555_5555, 32'h2222_2222, 3, 1'b0);

    // Fill past capacity: FIFO replacement of line 0
    do_reset();
    for (int i = 0; i <= 32; i++) write(pcof(i), dof(i));
    cmp("wrap.wptr", 32'(dut.wptr), 32'd1);
    for (int i = 0; i <= 32; i++) begin
      logic [1:0] h;
      h = {((32 - i) >= 1), (i >= 1)};
      probe($sformatf("fill%0d", i), 2'b11, pcof(i), pcof(32 - i), h,
            (i >= 1) ? dof(i) : 32'h0, ((32 - i) >= 1) ? dof(32 - i) : 32'h0, 32, 1'b1);
    end

    // Write + invalidate on different PCs while full
    wr_en = 1'b1; wr_pc = pcof(33); wr_inst = dof(33);
    inv_en = 1'b1; inv_pc = pcof(5);
    tick();
    probe("wr_inv_a", 2'b11, pcof(1), pcof(33), 2'b10, 0, dof(33), 31, 1'b0);
    probe("wr_inv_b", 2'b11, pcof(5), pcof(6), 2'b10, 0, dof(6), 31, 1'b0);

    // Invalidate targets the very line being reallocated
    wr_en = 1'b1; wr_pc = pcof(34); wr_inst = dof(34);
    inv_en = 1'b1; inv_pc = pcof(2);
    tick();
    probe("wr_inv_victim", 2'b11, pcof(2), pcof(34), 2'b10, 0, dof(34), 31, 1'b0);

    // Flush beats a simultaneous write
    do_reset();
    write(32'h1C00_0040, 32'h4040_4040);
    flush = 1'b1; wr_en = 1'b1; wr_pc = 32'h1C00_0080; wr_inst = 32'h8080_8080;
    tick();
    probe("flush", 2'b11, 32'h1C00_0040, 32'h1C00_0080, 2'b00, 0, 0, 0, 1'b0);

    // Write + invalidate on the same PC: write wins
    write(32'h1C00_00C0, 32'hC0C0_C0C0);
    wr_en = 1'b1; wr_pc = 32'h1C00_00C0; wr_inst = 32'hC1C1_C1C1;
    inv_en = 1'b1; inv_pc = 32'h1C00_00C0;
    tick();
    probe("wr_inv_same", 2'b01, 32'h1C00_00C0, 32'h0, 2'b01, 32'hC1C1_C1C1, 0, 1, 1'b0);
    wr_en = 1'b1; wr_pc = 32'h1C00_00D0; wr_inst = 32'hD0D0_D0D0;
    inv_en = 1'b1; inv_pc = 32'h1C00_00D0;
    tick();
    probe("wr_inv_new", 2'b11, 32'h1C00_00C0, 32'h1C00_00D0, 2'b11,
          32'hC1C1_C1C1, 32'hD0D0_D0D0, 2, 1'b0);

`ifdef ICACHE_PERF_CNT_EN
    do_reset();
    cmp("perf.reset_hit", hit_cnt, 32'd0);
    cmp("perf.reset_miss", miss_cnt, 32'd0);
    write(32'h1C00_0000, 32'h0280_0C0C);
    rd_en = 2'b11; rd_pc = {32'h1C00_0FF0, 32'h1C00_0000};
    for (int c = 0; c < 10; c++) @(posedge clk);
    #1;
    rd_en = 2'b00;
    cmp("perf.hit_cnt", hit_cnt, 32'd10);
    cmp("perf.miss_cnt", miss_cnt, 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
